// File: rtl/ift_pkg.sv
// Shared information-flow-tracking types plus the X-data taint gate used by
// the FIFO and by the taint-instrumented flop cells.
package ift_pkg;

  localparam int TAINT_W = 32;

  typedef logic [TAINT_W-1:0] taint_t;

  // 'data' is the reduction-XOR of the value being stored; an unknown parity
  // means the value itself is garbage, so its taint is dropped instead of kept.
  function automatic taint_t taint_gate(input logic data, input taint_t taint);
    return ((data !== 1'b0) && (data !== 1'b1)) ? '0 : taint;
  endfunction

endpackage

// File: rtl/ift_fifo_ctrl.sv
// Pointer, occupancy and flag control for the IFT FIFO, plus the sticky
// control-taint accumulator that covers occupancy, flags and read data.
module ift_fifo_ctrl
  import ift_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          arst_n,
  input  taint_t        arst_t,
  input  logic          wr_en,
  input  taint_t        wr_en_t,
  input  logic          rd_en,
  input  taint_t        rd_en_t,
  output logic          push_o,
  output logic          pop_o,
  output logic [PW-1:0] wptr_o,
  output logic [PW-1:0] rptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output taint_t        ctrl_t_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  taint_t        ctrl_t_q, ctrl_t_d;

  // Flags come only from the registered count, so accept decisions use the
  // state at the start of the cycle and nothing combinational reaches outputs.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_o  = wr_en && !full_o;
  assign pop_o   = rd_en && !empty_o;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    // A tainted enable shapes state even when deasserted or rejected.
    ctrl_t_d = ctrl_t_q | wr_en_t | rd_en_t;
    if (push_o) wptr_d = wptr_q + PW'(1);
    if (pop_o)  rptr_d = rptr_q + PW'(1);
    if (push_o && !pop_o)      count_d = count_q + CW'(1);
    else if (!push_o && pop_o) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ctrl_t_q <= arst_t;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ctrl_t_q <= ctrl_t_d;
    end
  end

  assign wptr_o   = wptr_q;
  assign rptr_o   = rptr_q;
  assign count_o  = count_q;
  assign ctrl_t_o = ctrl_t_q;

endmodule

// File: rtl/ift_fifo_sync.sv
// Taint-tracking synchronous FIFO: data and per-entry taint storage plus the
// registered read port; control and flags live in ift_fifo_ctrl.
module ift_fifo_sync
  import ift_pkg::*;
#(
  parameter int   WIDTH        = 2,
  parameter int   DEPTH        = 4,
  parameter logic CLK_POLARITY = 1'b1
) (
  input  logic                   CLK,
  input  taint_t                 CLK_t,
  input  logic                   ARST,
  input  taint_t                 ARST_t,
  input  logic                   WR_EN,
  input  taint_t                 WR_EN_t,
  input  logic [WIDTH-1:0]       D,
  input  taint_t                 D_t,
  input  logic                   RD_EN,
  input  taint_t                 RD_EN_t,
  output logic [WIDTH-1:0]       Q,
  output taint_t                 Q_t,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output taint_t                 FULL_t,
  output taint_t                 EMPTY_t,
  output taint_t                 COUNT_t
);

  localparam int PW = $clog2(DEPTH);

  logic             pos_clk;
  logic             push, pop;
  logic [PW-1:0]    wptr, rptr;
  taint_t           ctrl_t;
  logic             unused_clk_t;

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic [WIDTH-1:0] mem_d   [DEPTH];
  taint_t           mem_t_q [DEPTH];
  taint_t           mem_t_d [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  taint_t           q_t_q, q_t_d;

  assign pos_clk      = (CLK == CLK_POLARITY);
  assign unused_clk_t = ^CLK_t;

  ift_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (pos_clk),
    .arst_n   (ARST),
    .arst_t   (ARST_t),
    .wr_en    (WR_EN),
    .wr_en_t  (WR_EN_t),
    .rd_en    (RD_EN),
    .rd_en_t  (RD_EN_t),
    .push_o   (push),
    .pop_o    (pop),
    .wptr_o   (wptr),
    .rptr_o   (rptr),
    .count_o  (COUNT),
    .full_o   (FULL),
    .empty_o  (EMPTY),
    .ctrl_t_o (ctrl_t)
  );

  // Pop reads the pre-edge array, so a same-cycle write is never bypassed.
  always_comb begin
    mem_d   = mem_q;
    mem_t_d = mem_t_q;
    q_d     = q_q;
    q_t_d   = q_t_q;
    if (push) begin
      mem_d[wptr]   = D;
      mem_t_d[wptr] = taint_gate(^D, D_t | WR_EN_t);
    end
    if (pop) begin
      q_d   = mem_q[rptr];
      q_t_d = mem_t_q[rptr] | ctrl_t | RD_EN_t;
    end
  end

  always_ff @(posedge pos_clk) begin
    mem_q <= mem_d;
  end

  // Reset collapses all outstanding taint onto the reset's own taint.
  always_ff @(posedge pos_clk or negedge ARST) begin
    if (!ARST) begin
      mem_t_q <= '{default: '0};
      q_q     <= '0;
      q_t_q   <= ARST_t;
    end else begin
      mem_t_q <= mem_t_d;
      q_q     <= q_d;
      q_t_q   <= q_t_d;
    end
  end

  assign Q       = q_q;
  assign Q_t     = q_t_q;
  assign FULL_t  = ctrl_t;
  assign EMPTY_t = ctrl_t;
  assign COUNT_t = ctrl_t;

endmodule

// File: tb/tb_ift_fifo_sync.sv
// Directed self-checking bench for ift_fifo_sync: fill/drain, taint
// accumulation, simultaneous push/pop, wrap-around, X data and async reset.
module tb_ift_fifo_sync;
  import ift_pkg::*;

  logic       clk;
  taint_t     clk_t;
  logic       arst;
  taint_t     arst_t;
  logic       wr_en;
  taint_t     wr_en_t;
  logic [1:0] d;
  taint_t     d_t;
  logic       rd_en;
  taint_t     rd_en_t;
  logic [1:0] q;
  taint_t     q_t;
  logic       full, empty;
  logic [2:0] count;
  taint_t     full_t, empty_t, count_t;

  int         tests_run;
  int         tests_failed;
  logic [1:0] model_q[$];
  logic [1:0] exp_q;
  logic [1:0] dv;
  logic [1:0] d_x;
  logic       x_gated;

  ift_fifo_sync #(.WIDTH(2), .DEPTH(4), .CLK_POLARITY(1'b1)) dut (
    .CLK     (clk),
    .CLK_t   (clk_t),
    .ARST    (arst),
    .ARST_t  (arst_t),
    .WR_EN   (wr_en),
    .WR_EN_t (wr_en_t),
    .D       (d),
    .D_t     (d_t),
    .RD_EN   (rd_en),
    .RD_EN_t (rd_en_t),
    .Q       (q),
    .Q_t     (q_t),
    .FULL    (full),
    .EMPTY   (empty),
    .COUNT   (count),
    .FULL_t  (full_t),
    .EMPTY_t (empty_t),
    .COUNT_t (count_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the active edge.
  task automatic applyStimulus(input logic wr, input taint_t wrt, input logic [1:0] dval,
                               input taint_t dtv, input logic rd, input taint_t rdt);
    wr_en   = wr;
    wr_en_t = wrt;
    d       = dval;
    d_t     = dtv;
    rd_en   = rd;
    rd_en_t = rdt;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input taint_t t);
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    arst_t = t;
    #2 arst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk_t   = '0;
    arst    = 1'b1;
    arst_t  = '0;
    wr_en   = 1'b0;
    wr_en_t = '0;
    d       = '0;
    d_t     = '0;
    rd_en   = 1'b0;
    rd_en_t = '0;

    // Reset with tainted reset, check reset state while still held low.
    arst_t = 32'h1;
    #2 arst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_count",   32'(count), 32'd0);
    checkOutput("rst_empty",   32'(empty), 32'd1);
    checkOutput("rst_full",    32'(full),  32'd0);
    checkOutput("rst_q",       32'(q),     32'd0);
    checkOutput("rst_q_t",     q_t,        32'h1);
    checkOutput("rst_empty_t", empty_t,    32'h1);
    arst   = 1'b1;
    arst_t = '0;

    // Fill with 1,2,3,0.
    applyStimulus(1'b1, '0, 2'd1, 32'h10, 1'b0, '0);
    checkOutput("fill1_count", 32'(count), 32'd1);
    applyStimulus(1'b1, '0, 2'd2, 32'h10, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd3, 32'h10, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd0, 32'h10, 1'b0, '0);
    checkOutput("fill_full",    32'(full),  32'd1);
    checkOutput("fill_count",   32'(count), 32'd4);
    checkOutput("fill_full_t",  full_t,     32'h1);
    checkOutput("fill_count_t", count_t,    32'h1);
    applyStimulus(1'b1, '0, 2'd2, 32'h10, 1'b0, '0);
    checkOutput("push_full_count", 32'(count), 32'd4);

    // Drain in order.
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("drain0_q",   32'(q), 32'd1);
    checkOutput("drain0_q_t", q_t,    32'h11);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("drain1_q",   32'(q), 32'd2);
    checkOutput("drain1_q_t", q_t,    32'h11);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("drain2_q",   32'(q), 32'd3);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("drain3_q",    32'(q),     32'd0);
    checkOutput("drain3_q_t",  q_t,        32'h11);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("pop_empty_q",     32'(q),     32'd0);
    checkOutput("pop_empty_q_t",   q_t,        32'h11);
    checkOutput("pop_empty_count", 32'(count), 32'd0);

    // Tainted idle write enable.
    doReset('0);
    applyStimulus(1'b0, 32'h100, 2'd0, '0, 1'b0, '0);
    checkOutput("idle_count",   32'(count), 32'd0);
    checkOutput("idle_empty_t", empty_t,    32'h100);
    applyStimulus(1'b1, '0, 2'd3, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("idle_pop_q",   32'(q), 32'd3);
    checkOutput("idle_pop_q_t", q_t,    32'h100);

    // Simultaneous push and pop at full, empty and mid occupancy.
    doReset('0);
    applyStimulus(1'b1, '0, 2'd0, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd1, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd2, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd3, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd1, '0, 1'b1, '0);
    checkOutput("both_full_count", 32'(count), 32'd3);
    checkOutput("both_full_q",     32'(q),     32'd0);
    checkOutput("both_full_flag",  32'(full),  32'd0);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("after_full_q",     32'(q),     32'd3);
    checkOutput("after_full_count", 32'(count), 32'd0);
    applyStimulus(1'b1, '0, 2'd2, '0, 1'b1, '0);
    checkOutput("both_empty_count", 32'(count), 32'd1);
    checkOutput("both_empty_q",     32'(q),     32'd3);
    applyStimulus(1'b1, '0, 2'd1, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd3, '0, 1'b1, '0);
    checkOutput("both_mid_count", 32'(count), 32'd2);
    checkOutput("both_mid_q",     32'(q),     32'd2);

    // Wrap-around with a tainted idle read enable folded into ctrl taint.
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b0, 32'h40);
    model_q = '{2'd1, 2'd3};
    for (int k = 0; k < 10; k++) begin
      dv = 2'(k + 1);
      applyStimulus(1'b1, '0, dv, '0, 1'b1, '0);
      model_q.push_back(dv);
      exp_q = model_q.pop_front();
      checkOutput("wrap_q", 32'(q), 32'(exp_q));
    end
    checkOutput("wrap_count", 32'(count), 32'd2);
    checkOutput("wrap_q_t",   q_t,        32'h40);

    // X data: its own taint is dropped where the simulator can see the X.
    d_x     = 2'bxx;
    x_gated = ((^d_x) !== 1'b0) && ((^d_x) !== 1'b1);
    applyStimulus(1'b1, '0, d_x, 32'hF, 1'b0, '0);
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    exp_q = model_q.pop_front();
    checkOutput("x_pre0_q", 32'(q), 32'(exp_q));
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    exp_q = model_q.pop_front();
    checkOutput("x_pre1_q", 32'(q), 32'(exp_q));
    applyStimulus(1'b0, '0, 2'd0, '0, 1'b1, '0);
    checkOutput("x_pop_q_t",   q_t,        x_gated ? 32'h40 : 32'h4F);
    checkOutput("x_pop_count", 32'(count), 32'd0);

    // Async reset between edges with three entries held.
    applyStimulus(1'b1, '0, 2'd1, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd2, '0, 1'b0, '0);
    applyStimulus(1'b1, '0, 2'd3, '0, 1'b0, '0);
    checkOutput("pre_arst_count", 32'(count), 32'd3);
    wr_en  = 1'b0;
    arst_t = 32'h2;
    #1 arst = 1'b0;
    #1;
    checkOutput("arst_count",   32'(count), 32'd0);
    checkOutput("arst_q",       32'(q),     32'd0);
    checkOutput("arst_q_t",     q_t,        32'h2);
    checkOutput("arst_empty_t", empty_t,    32'h2);
    checkOutput("arst_empty",   32'(empty), 32'd1);
    #2 arst = 1'b1;
    applyStimulus(1'b1, '0, 2'd1, '0, 1'b0, '0);
    checkOutput("post_arst_count",   32'(count), 32'd1);
    checkOutput("post_arst_empty_t", empty_t,    32'h2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ift_fifo_sync.md
# ift_fifo_sync

Information-flow-tracking (IFT) synchronous FIFO that sits directly downstream of the taint-instrumented enable/sync-reset flop stage. It buffers that stage's `Q`/`Q_t` output as `D`/`D_t`, and each entry carries its 32-bit taint tag alongside the data. A sticky control-taint accumulator records the influence of tainted enables and reset on occupancy, flags and read data. Use it wherever a tracked datapath needs elastic buffering without losing or under-reporting taint.

## Interface
- `WIDTH`, 2, data width
- `DEPTH`, 4, entry count; power of two, ≥2
- `CLK_POLARITY`, 1'b1, active clock edge (`pos_clk = CLK == CLK_POLARITY`)
- `CLK` in 1: clock
- `CLK_t` in 32: clock taint; unused, kept for port uniformity
- `ARST` in 1: reset; asynchronous, active-low (fixed, no polarity parameter)
- `ARST_t` in 32: reset taint
- `WR_EN` / `WR_EN_t` in 1 / 32: push request and its taint
- `D` / `D_t` in WIDTH / 32: write data and its taint
- `RD_EN` / `RD_EN_t` in 1 / 32: pop request and its taint
- `Q` / `Q_t` out WIDTH / 32: registered read data and its taint
- `FULL`, `EMPTY` out 1: occupancy flags
- `COUNT` out $clog2(DEPTH)+1: occupancy
- `FULL_t`, `EMPTY_t`, `COUNT_t` out 32: flag/count taint

## Operation
- Push accepted: `WR_EN && !FULL`. Writes `mem[wptr] <= D` and `mem_t[wptr] <= (^D === 1'bx) ? 0 : (D_t | WR_EN_t)`. `wptr` increments.
- Pop accepted: `RD_EN && !EMPTY`. Sets `Q <= mem[rptr]` and `Q_t <= mem_t[rptr] | ctrl_t | RD_EN_t`. `rptr` increments. With no accepted pop, `Q`/`Q_t` hold.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `COUNT` is a separate register.
  - Push only: +1. Pop only: −1. Both or neither: unchanged.
- `FULL = (COUNT == DEPTH)`; `EMPTY = (COUNT == 0)`. Both are decoded from registered `COUNT`.
- `ctrl_t` is a 32-bit sticky accumulator, updated every active edge: `ctrl_t <= ctrl_t | WR_EN_t | RD_EN_t`. It is ORed even when the enable is deasserted or the request is rejected, because a tainted non-request still shapes state. It clears only on reset.
- `FULL_t = EMPTY_t = COUNT_t = ctrl_t`.
- Boundary rules:
  - Push when full: rejected, no state change except `ctrl_t`.
  - Pop when empty: rejected, `Q`/`Q_t` hold; no bypass of same-cycle write.
  - Push+pop when full: pop accepted, push rejected (flags sampled at cycle start).
  - Push+pop when empty: push accepted, pop rejected.
  - Push+pop otherwise: both accepted, `COUNT` unchanged.

## Timing
- Reset (`ARST` low), asynchronous and immediate:
  - `wptr = rptr = 0`, `COUNT = 0`, `EMPTY = 1`, `FULL = 0`, `Q = 0`.
  - `Q_t = ARST_t`, `ctrl_t = ARST_t`, all `mem_t = 0`. `mem` is not reset.
- Release: the first active edge after `ARST` rises may accept a push.
- Reset mid-operation discards all entries. Outstanding taint collapses to `ARST_t` on `Q_t` and the flag taints.
- Write-to-read latency: a push at edge N is poppable at edge N+1, with `Q` valid after edge N+1. Minimum two edges from push to `Q`.
- Read latency: `Q`/`Q_t` update on the same edge that accepts the pop.
- Flags and `COUNT` reflect the state after the latest edge. There is no combinational path from `WR_EN`/`RD_EN` to outputs.

## Structure
- Shared package `ift_pkg`:
  - `TAINT_W = 32` and `typedef logic [TAINT_W-1:0] taint_t`.
  - Function `taint_gate(data, taint)` implementing the X-data → 0 rule, shared with the flop cells.
- Sub-module `ift_fifo_ctrl` holds the pointers, `COUNT`, flags, accept logic and `ctrl_t`.
- Top holds the `mem`/`mem_t` arrays and the `Q`/`Q_t` register.

## Test plan
- Reset then fill: `ARST` low with `ARST_t = 32'h1`, release, push D=1,2,3,0 with `D_t = 32'h10`, untainted enables.
  - Required: `FULL = 1`, `COUNT = 4`, `FULL_t = 32'h1`.
  - Then a push with D=2 is rejected, and `COUNT` stays 4.
- Drain order: from the full state, pop four times.
  - Required: `Q` = 1, 2, 3, 0 and `Q_t = 32'h11` each.
  - Then `EMPTY = 1`; a fifth pop holds `Q = 0`.
- Tainted idle enable: empty FIFO, `WR_EN = 0` with `WR_EN_t = 32'h100` for one cycle.
  - Required: `COUNT` stays 0, `EMPTY_t = 32'h100`.
  - A subsequent push of D=3 with `D_t = 0`, then pop, gives `Q_t = 32'h100`.
- Simultaneous push/pop:
  - At full, push D=1 + pop: `COUNT` 4→3 and the oldest entry is output.
  - At empty, push D=2 + pop: `COUNT` 0→1, `Q` unchanged.
  - With `COUNT = 2`, push + pop: `COUNT` stays 2.
- Wrap-around and X: perform 10 push/pop pairs so the pointers wrap; data order is preserved.
  - Push D=2'bx with `D_t = 32'hF`; on pop, `Q_t` equals `ctrl_t` only.
- Async reset mid-operation: with `COUNT = 3`, drop `ARST` between edges with `ARST_t = 32'h2`.
  - Required immediately: `COUNT = 0`, `Q = 0`, `Q_t = 32'h2`, `EMPTY_t = 32'h2`.
